// File: rtl/memory_pkg.sv
// Shared types for the memory stage: memory op encodings, access sizes,
// writeback selector and register index types, plus op classification helpers.
package memory_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LW   = 4'd3,
        MEM_OP_LBU  = 4'd4,
        MEM_OP_LHU  = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    typedef enum logic [1:0] {
        WB_SRC_RESULT  = 2'd0,
        WB_SRC_PC_NEXT = 2'd1,
        WB_SRC_CSR     = 2'd2,
        WB_SRC_IMM     = 2'd3
    } writeback_source_e;

    typedef logic [4:0] register_t;

    typedef enum logic {
        STATE_IDLE     = 1'b0,
        STATE_WAIT_RSP = 1'b1
    } mem_state_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic access_size_e access_size(input mem_op_e op);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return SIZE_HALF;
            MEM_OP_LW, MEM_OP_SW:             return SIZE_WORD;
            default:                          return SIZE_BYTE;
        endcase
    endfunction

    function automatic logic is_aligned(input mem_op_e op, input logic [1:0] addr_lo);
        case (access_size(op))
            SIZE_HALF: return addr_lo[0] == 1'b0;
            SIZE_WORD: return addr_lo == 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_aligner.sv
// Combinational lane steering: store strobe/data replication toward the bus
// and byte/half selection with sign or zero extension for returning loads.
module load_store_aligner
    import memory_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_value_o
);

    logic [31:0] rdata_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        strobe_o = 4'b0000;
        wdata_o  = 32'h0;
        case (access_size(op_i))
            SIZE_BYTE: begin
                strobe_o = 4'b0001 << addr_lo_i;
                wdata_o  = {4{store_data_i[7:0]}};
            end
            SIZE_HALF: begin
                strobe_o = 4'b0011 << addr_lo_i;
                wdata_o  = {2{store_data_i[15:0]}};
            end
            default: begin
                strobe_o = 4'b1111;
                wdata_o  = store_data_i;
            end
        endcase
    end

    // The byte lane is picked by shifting the word down by 8 * addr[1:0].
    always_comb begin
        rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
        load_byte     = rdata_shifted[7:0];
        load_half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            MEM_OP_LB:  load_value_o = {{24{load_byte[7]}}, load_byte};
            MEM_OP_LBU: load_value_o = {24'h0, load_byte};
            MEM_OP_LH:  load_value_o = {{16{load_half[15]}}, load_half};
            MEM_OP_LHU: load_value_o = {16'h0, load_half};
            MEM_OP_LW:  load_value_o = rdata_i;
            default:    load_value_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on the data bus, stalls upstream
// while an access is outstanding, and registers every writeback-bound field.
module memory_stage
    import memory_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  mem_op_e           mem_op_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  writeback_source_e writeback_source_selector_i,
    input  logic [31:0]       pc_next_sequential_i,
    input  logic              write_enable_i,
    input  register_t         rd_address_i,
    output logic              stall_o,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic [31:0]       dmem_req_address_o,
    output logic              dmem_req_write_o,
    output logic [3:0]        dmem_req_strobe_o,
    output logic [31:0]       dmem_req_wdata_o,
    input  logic              dmem_rsp_valid_i,
    input  logic [31:0]       dmem_rsp_rdata_i,
    output logic              valid_o,
    output writeback_source_e writeback_source_selector_o,
    output logic [31:0]       result_o,
    output logic [31:0]       pc_next_sequential_o,
    output logic              write_enable_o,
    output register_t         rd_address_o,
    output logic              misaligned_o
);

    mem_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    writeback_source_e wb_sel_q, wb_sel_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       pc_next_q, pc_next_d;
    logic              write_enable_q, write_enable_d;
    register_t         rd_address_q, rd_address_d;
    logic              misaligned_q, misaligned_d;

    logic        has_mem_op;
    logic        aligned;
    logic        mem_access;
    logic        misaligned;
    logic        stall;
    logic [31:0] load_value;

    assign has_mem_op = valid_i && (mem_op_i != MEM_OP_NONE);
    assign aligned    = is_aligned(mem_op_i, alu_result_i[1:0]);
    assign mem_access = has_mem_op && aligned;
    assign misaligned = has_mem_op && !aligned;

    load_store_aligner u_aligner (
        .op_i         (mem_op_i),
        .addr_lo_i    (alu_result_i[1:0]),
        .store_data_i (store_data_i),
        .rdata_i      (dmem_rsp_rdata_i),
        .strobe_o     (dmem_req_strobe_o),
        .wdata_o      (dmem_req_wdata_o),
        .load_value_o (load_value)
    );

    assign dmem_req_address_o = {alu_result_i[31:2], 2'b00};
    assign dmem_req_write_o   = is_store(mem_op_i);
    assign stall_o            = stall;

    // Responses seen in IDLE fall through untouched, so stray acks are dropped.
    always_comb begin
        state_d          = state_q;
        stall            = 1'b0;
        dmem_req_valid_o = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                dmem_req_valid_o = mem_access;
                stall            = mem_access;
                if (mem_access && dmem_req_ready_i) begin
                    state_d = STATE_WAIT_RSP;
                end
            end
            STATE_WAIT_RSP: begin
                stall = !dmem_rsp_valid_i;
                if (dmem_rsp_valid_i) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_comb begin
        valid_d        = valid_q;
        wb_sel_d       = wb_sel_q;
        result_d       = result_q;
        pc_next_d      = pc_next_q;
        write_enable_d = write_enable_q;
        rd_address_d   = rd_address_q;
        misaligned_d   = misaligned_q;
        if (stall) begin
            valid_d        = 1'b0;
            write_enable_d = 1'b0;
        end else begin
            valid_d        = valid_i;
            wb_sel_d       = writeback_source_selector_i;
            result_d       = (mem_access && is_load(mem_op_i)) ? load_value : alu_result_i;
            pc_next_d      = pc_next_sequential_i;
            write_enable_d = write_enable_i && !is_store(mem_op_i) && !misaligned;
            rd_address_d   = rd_address_i;
            misaligned_d   = misaligned;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= STATE_IDLE;
            valid_q        <= 1'b0;
            wb_sel_q       <= WB_SRC_RESULT;
            result_q       <= 32'h0;
            pc_next_q      <= 32'h0;
            write_enable_q <= 1'b0;
            rd_address_q   <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            wb_sel_q       <= wb_sel_d;
            result_q       <= result_d;
            pc_next_q      <= pc_next_d;
            write_enable_q <= write_enable_d;
            rd_address_q   <= rd_address_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign valid_o                     = valid_q;
    assign writeback_source_selector_o = wb_sel_q;
    assign result_o                    = result_q;
    assign pc_next_sequential_o        = pc_next_q;
    assign write_enable_o              = write_enable_q;
    assign rd_address_o                = rd_address_q;
    assign misaligned_o                = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change on the falling edge, outputs
// are sampled mid-low-phase (combinational) or 1ns after the rising edge.
module tb_memory_stage;
    import memory_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in;
    mem_op_e           mem_op;
    logic [31:0]       alu_result;
    logic [31:0]       store_data;
    writeback_source_e wb_sel_in;
    logic [31:0]       pc_next_in;
    logic              we_in;
    register_t         rd_in;
    logic              stall;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_write;
    logic [3:0]        req_strobe;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              valid_out;
    writeback_source_e wb_sel_out;
    logic [31:0]       result_out;
    logic [31:0]       pc_out;
    logic              we_out;
    register_t         rd_out;
    logic              misaligned_out;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .valid_i                     (valid_in),
        .mem_op_i                    (mem_op),
        .alu_result_i                (alu_result),
        .store_data_i                (store_data),
        .writeback_source_selector_i (wb_sel_in),
        .pc_next_sequential_i        (pc_next_in),
        .write_enable_i              (we_in),
        .rd_address_i                (rd_in),
        .stall_o                     (stall),
        .dmem_req_valid_o            (req_valid),
        .dmem_req_ready_i            (req_ready),
        .dmem_req_address_o          (req_addr),
        .dmem_req_write_o            (req_write),
        .dmem_req_strobe_o           (req_strobe),
        .dmem_req_wdata_o            (req_wdata),
        .dmem_rsp_valid_i            (rsp_valid),
        .dmem_rsp_rdata_i            (rsp_rdata),
        .valid_o                     (valid_out),
        .writeback_source_selector_o (wb_sel_out),
        .result_o                    (result_out),
        .pc_next_sequential_o        (pc_out),
        .write_enable_o              (we_out),
        .rd_address_o                (rd_out),
        .misaligned_o                (misaligned_out)
    );

    task automatic idle_inputs();
        valid_in   = 1'b0;
        mem_op     = MEM_OP_NONE;
        alu_result = 32'h0;
        store_data = 32'h0;
        wb_sel_in  = WB_SRC_RESULT;
        pc_next_in = 32'h0;
        we_in      = 1'b0;
        rd_in      = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'h0;
    endtask

    task automatic drive_op(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic we, input register_t rd);
        valid_in   = 1'b1;
        mem_op     = op;
        alu_result = addr;
        store_data = sdata;
        we_in      = we;
        rd_in      = rd;
        pc_next_in = addr + 32'd4;
        wb_sel_in  = WB_SRC_RESULT;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        check_count++; if (valid_out !== 1'b0) begin error_count++; $display("FAIL reset_valid got %b want 0", valid_out); end
        check_count++; if (we_out !== 1'b0) begin error_count++; $display("FAIL reset_we got %b want 0", we_out); end
        check_count++; if (misaligned_out !== 1'b0) begin error_count++; $display("FAIL reset_misaligned got %b want 0", misaligned_out); end
        check_count++; if (result_out !== 32'h0) begin error_count++; $display("FAIL reset_result got %h want 0", result_out); end
        check_count++; if (req_valid !== 1'b0) begin error_count++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        drive_op(MEM_OP_NONE, 32'h1234, 32'h0, 1'b1, 5'd5);
        wb_sel_in  = WB_SRC_PC_NEXT;
        pc_next_in = 32'h0000_0044;
        #1;
        check_count++; if (req_valid !== 1'b0) begin error_count++; $display("FAIL alu_req_valid got %b want 0", req_valid); end
        check_count++; if (stall !== 1'b0) begin error_count++; $display("FAIL alu_stall got %b want 0", stall); end
        @(posedge clk); #1;
        check_count++; if (valid_out !== 1'b1) begin error_count++; $display("FAIL alu_valid got %b want 1", valid_out); end
        check_count++; if (result_out !== 32'h1234) begin error_count++; $display("FAIL alu_result got %h want 00001234", result_out); end
        check_count++; if (rd_out !== 5'd5) begin error_count++; $display("FAIL alu_rd got %0d want 5", rd_out); end
        check_count++; if (we_out !== 1'b1) begin error_count++; $display("FAIL alu_we got %b want 1", we_out); end
        check_count++; if (pc_out !== 32'h44) begin error_count++; $display("FAIL alu_pc got %h want 00000044", pc_out); end
        check_count++; if (wb_sel_out !== WB_SRC_PC_NEXT) begin error_count++; $display("FAIL alu_wb_sel got %0d want 1", wb_sel_out); end
        check_count++; if (misaligned_out !== 1'b0) begin error_count++; $display("FAIL alu_misaligned got %b want 0", misaligned_out); end
    endtask

    task automatic test_load_byte();
        @(negedge clk);
        idle_inputs();
        drive_op(MEM_OP_LB, 32'h103, 32'h0, 1'b1, 5'd7);
        req_ready = 1'b1;
        #1;
        check_count++; if (req_valid !== 1'b1) begin error_count++; $display("FAIL lb_req_valid got %b want 1", req_valid); end
        check_count++; if (req_addr !== 32'h100) begin error_count++; $display("FAIL lb_req_addr got %h want 00000100", req_addr); end
        check_count++; if (req_write !== 1'b0) begin error_count++; $display("FAIL lb_req_write got %b want 0", req_write); end
        check_count++; if (stall !== 1'b1) begin error_count++; $display("FAIL lb_stall_accept got %b want 1", stall); end
        @(posedge clk); #1;
        check_count++; if (valid_out !== 1'b0) begin error_count++; $display("FAIL lb_bubble_valid got %b want 0", valid_out); end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h80FF_FFFF;
        #1;
        check_count++; if (req_valid !== 1'b0) begin error_count++; $display("FAIL lb_req_valid_wait got %b want 0", req_valid); end
        check_count++; if (stall !== 1'b0) begin error_count++; $display("FAIL lb_stall_rsp got %b want 0", stall); end
        @(posedge clk); #1;
        check_count++; if (result_out !== 32'hFFFF_FF80) begin error_count++; $display("FAIL lb_result got %h want ffffff80", result_out); end
        check_count++; if (we_out !== 1'b1) begin error_count++; $display("FAIL lb_we got %b want 1", we_out); end
        check_count++; if (valid_out !== 1'b1) begin error_count++; $display("FAIL lb_valid got %b want 1", valid_out); end
        check_count++; if (rd_out !== 5'd7) begin error_count++; $display("FAIL lb_rd got %0d want 7", rd_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive_op(MEM_OP_LHU, 32'h202, 32'h0, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_count++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin error_count++; $display("FAIL bp_req_held[%0d] got valid %b addr %h want 1 00000200", i, req_valid, req_addr); end
            check_count++; if (stall !== 1'b1) begin error_count++; $display("FAIL bp_stall[%0d] got %b want 1", i, stall); end
            @(posedge clk); #1;
            check_count++; if (valid_out !== 1'b0) begin error_count++; $display("FAIL bp_valid[%0d] got %b want 0", i, valid_out); end
            @(negedge clk);
        end
        req_ready = 1'b1;
        #1;
        check_count++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin error_count++; $display("FAIL bp_req_accept got valid %b addr %h want 1 00000200", req_valid, req_addr); end
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check_count++; if (stall !== 1'b1 || req_valid !== 1'b0) begin error_count++; $display("FAIL bp_wait got stall %b req %b want 1 0", stall, req_valid); end
        @(posedge clk); #1;
        check_count++; if (valid_out !== 1'b0) begin error_count++; $display("FAIL bp_wait_valid got %b want 0", valid_out); end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_rdata = 32'hBEEF_0000;
        @(posedge clk); #1;
        check_count++; if (result_out !== 32'h0000_BEEF) begin error_count++; $display("FAIL lhu_result got %h want 0000beef", result_out); end
        check_count++; if (valid_out !== 1'b1 || we_out !== 1'b1) begin error_count++; $display("FAIL lhu_valid_we got %b %b want 1 1", valid_out, we_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        drive_op(MEM_OP_SB, 32'h301, 32'h0000_00AB, 1'b1, 5'd3);
        req_ready = 1'b1;
        #1;
        check_count++; if (req_strobe !== 4'b0010) begin error_count++; $display("FAIL sb_strobe got %b want 0010", req_strobe); end
        check_count++; if (req_wdata !== 32'hABAB_ABAB) begin error_count++; $display("FAIL sb_wdata got %h want abababab", req_wdata); end
        check_count++; if (req_write !== 1'b1 || req_valid !== 1'b1) begin error_count++; $display("FAIL sb_req got write %b valid %b want 1 1", req_write, req_valid); end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        @(posedge clk); #1;
        check_count++; if (valid_out !== 1'b1) begin error_count++; $display("FAIL sb_valid got %b want 1", valid_out); end
        check_count++; if (we_out !== 1'b0) begin error_count++; $display("FAIL sb_we got %b want 0", we_out); end
        check_count++; if (result_out !== 32'h301) begin error_count++; $display("FAIL sb_result got %h want 00000301", result_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_store_half_load_half();
        @(negedge clk);
        drive_op(MEM_OP_SH, 32'h302, 32'hFFFF_1234, 1'b0, 5'd0);
        req_ready = 1'b1;
        #1;
        check_count++; if (req_strobe !== 4'b1100) begin error_count++; $display("FAIL sh_strobe got %b want 1100", req_strobe); end
        check_count++; if (req_wdata !== 32'h1234_1234) begin error_count++; $display("FAIL sh_wdata got %h want 12341234", req_wdata); end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        @(negedge clk);
        idle_inputs();
        drive_op(MEM_OP_LH, 32'h500, 32'h0, 1'b1, 5'd11);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1111_8001;
        @(posedge clk); #1;
        check_count++; if (result_out !== 32'hFFFF_8001) begin error_count++; $display("FAIL lh_result got %h want ffff8001", result_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive_op(MEM_OP_LW, 32'h402, 32'h0, 1'b1, 5'd4);
        req_ready = 1'b1;
        #1;
        check_count++; if (req_valid !== 1'b0 || stall !== 1'b0) begin error_count++; $display("FAIL mis_req_stall got %b %b want 0 0", req_valid, stall); end
        @(posedge clk); #1;
        check_count++; if (misaligned_out !== 1'b1) begin error_count++; $display("FAIL mis_flag got %b want 1", misaligned_out); end
        check_count++; if (we_out !== 1'b0 || valid_out !== 1'b1) begin error_count++; $display("FAIL mis_we_valid got %b %b want 0 1", we_out, valid_out); end
        @(negedge clk);
        idle_inputs();
        drive_op(MEM_OP_NONE, 32'h402, 32'h0, 1'b1, 5'd4);
        @(posedge clk); #1;
        check_count++; if (misaligned_out !== 1'b0) begin error_count++; $display("FAIL mis_clear got %b want 0", misaligned_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive_op(MEM_OP_LW, 32'h400, 32'h0, 1'b1, 5'd6);
        req_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        check_count++; if (valid_out !== 1'b0 || result_out !== 32'h0 || rd_out !== 5'd0) begin error_count++; $display("FAIL rma_outputs got %b %h %0d want 0 0 0", valid_out, result_out, rd_out); end
        check_count++; if (stall !== 1'b0 || req_valid !== 1'b0) begin error_count++; $display("FAIL rma_stall_req got %b %b want 0 0", stall, req_valid); end
        @(negedge clk);
        rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        #1;
        check_count++; if (stall !== 1'b0) begin error_count++; $display("FAIL rma_stray_stall got %b want 0", stall); end
        @(posedge clk); #1;
        check_count++; if (valid_out !== 1'b0 || result_out !== 32'h0) begin error_count++; $display("FAIL rma_stray_out got %b %h want 0 0", valid_out, result_out); end
        @(negedge clk);
        idle_inputs();
        drive_op(MEM_OP_LW, 32'h500, 32'h0, 1'b1, 5'd6);
        #1;
        check_count++; if (req_valid !== 1'b1 || stall !== 1'b1) begin error_count++; $display("FAIL rma_idle_state got req %b stall %b want 1 1", req_valid, stall); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_byte();
        test_backpressure();
        test_store_byte();
        test_store_half_load_half();
        test_misaligned();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
